// File: rtl/mult_accum_pkg.sv
// Shared types, default widths and the saturating adder for the signed
// product accumulator.
package mult_accum_pkg;

   typedef enum logic [1:0] {IDLE, ACC, OUT} accum_state_t;

   localparam int R_WIDTH_DEF   = 43;
   localparam int ACC_WIDTH_DEF = 48;
   localparam int CNT_WIDTH_DEF = 8;
   // Widest accumulator the adder supports; callers sign-extend into this.
   localparam int ACC_MAX_W     = 64;

   // Adds two sign-extended operands with one guard bit and clamps the result
   // to the signed range of an acc_w-bit accumulator. Returns {sat_hit, result}.
   function automatic logic [ACC_MAX_W:0] sat_add(
      input logic signed [ACC_MAX_W-1:0] acc,
      input logic signed [ACC_MAX_W-1:0] prod,
      input int                          acc_w
   );
      logic signed [ACC_MAX_W:0] one;
      logic signed [ACC_MAX_W:0] s;
      logic signed [ACC_MAX_W:0] s_max;
      logic signed [ACC_MAX_W:0] s_min;
      one   = 1;
      s     = {acc[ACC_MAX_W-1], acc} + {prod[ACC_MAX_W-1], prod};
      s_max = (one <<< (acc_w - 1)) - one;
      s_min = -(one <<< (acc_w - 1));
      if (s > s_max) begin
         sat_add = {1'b1, s_max[ACC_MAX_W-1:0]};
      end else if (s < s_min) begin
         sat_add = {1'b1, s_min[ACC_MAX_W-1:0]};
      end else begin
         sat_add = {1'b0, s[ACC_MAX_W-1:0]};
      end
   endfunction

endpackage

// File: rtl/mult_accum_seq.sv
// Accumulates a last-delimited vector of signed products into a saturating
// accumulator and presents the dot-product result on a valid/ready output.
module mult_accum_seq
   import mult_accum_pkg::*;
#(
   parameter int R_WIDTH   = R_WIDTH_DEF,
   parameter int ACC_WIDTH = ACC_WIDTH_DEF,  // R_WIDTH <= ACC_WIDTH <= ACC_MAX_W
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
)(
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic signed [R_WIDTH-1:0]   prod_i,
   input  logic                        prod_valid_i,
   input  logic                        prod_last_i,
   output logic                        prod_ready_o,
   output logic signed [ACC_WIDTH-1:0] sum_o,
   output logic [CNT_WIDTH-1:0]        sum_cnt_o,
   output logic                        sum_ovf_o,
   output logic                        sum_valid_o,
   input  logic                        sum_ready_i
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high. A producer holds data stable while valid && !ready, and ready
   // never depends combinationally on valid.
   accum_state_t state_q, state_d;

   logic signed [ACC_WIDTH-1:0] acc_q, acc_d, sum_d, acc_sat;
   logic [CNT_WIDTH-1:0]        cnt_q, cnt_d, sum_cnt_d, cnt_inc;
   logic                        ovf_q, ovf_d, sum_ovf_d, sum_valid_d;
   logic signed [ACC_MAX_W-1:0] acc_ext, prod_ext;
   logic [ACC_MAX_W:0]          add_res;
   logic                        sat_hit;
   logic                        accept;

   assign prod_ready_o = (state_q != OUT);
   assign accept       = prod_valid_i && prod_ready_o;

   assign acc_ext  = ACC_MAX_W'(acc_q);
   assign prod_ext = ACC_MAX_W'(prod_i);
   assign add_res  = sat_add(acc_ext, prod_ext, ACC_WIDTH);
   assign sat_hit  = add_res[ACC_MAX_W];
   assign acc_sat  = add_res[ACC_WIDTH-1:0];
   // Beat count sticks at all-ones for overlong vectors.
   assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      sum_d       = sum_o;
      sum_cnt_d   = sum_cnt_o;
      sum_ovf_d   = sum_ovf_o;
      sum_valid_d = sum_valid_o;
      case (state_q)
         IDLE: begin
            if (accept) begin
               acc_d   = prod_ext[ACC_WIDTH-1:0];
               cnt_d   = CNT_WIDTH'(1);
               ovf_d   = 1'b0;
               state_d = prod_last_i ? OUT : ACC;
            end
         end
         ACC: begin
            if (accept) begin
               acc_d = acc_sat;
               cnt_d = cnt_inc;
               ovf_d = ovf_q | sat_hit;
               if (prod_last_i) state_d = OUT;
            end
         end
         OUT: begin
            if (sum_ready_i) begin
               sum_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // The final beat publishes its own post-update totals on the same edge.
      if (accept && prod_last_i) begin
         sum_d       = acc_d;
         sum_cnt_d   = cnt_d;
         sum_ovf_d   = ovf_d;
         sum_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         sum_o       <= '0;
         sum_cnt_o   <= '0;
         sum_ovf_o   <= 1'b0;
         sum_valid_o <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         sum_o       <= sum_d;
         sum_cnt_o   <= sum_cnt_d;
         sum_ovf_o   <= sum_ovf_d;
         sum_valid_o <= sum_valid_d;
      end
   end

endmodule

// File: tb/tb_mult_accum_seq.sv
// Bench for mult_accum_seq: a default 48-bit instance plus a 44-bit instance
// that exercises saturation, both driven from the same stimulus.
module tb_mult_accum_seq;
   import mult_accum_pkg::*;

   localparam int RW  = 43;
   localparam int AW  = 48;
   localparam int AWS = 44;
   localparam int CW  = 8;
   localparam int W   = 1 + CW + AW;
   localparam int WS  = 1 + CW + AWS;
   localparam longint P42 = 64'sd1 <<< 42;
   localparam longint P43 = 64'sd1 <<< 43;
   localparam longint OVF_V [3][4] = '{'{P42 - 1, P42 - 1, 2, 0},
                                       '{-P42, -P42, -2, 0},
                                       '{P42 - 1, P42 - 1, 2, -5}};
   localparam int     OVF_LEN [3] = '{3, 3, 4};
   localparam longint OVF_E44 [3] = '{P43 - 1, -P43, P43 - 6};
   localparam longint OVF_E48 [3] = '{P43, -P43 - 2, P43 - 5};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic signed [RW-1:0] prod = '0;
   logic prod_valid = 1'b0;
   logic prod_last  = 1'b0;
   logic sum_ready  = 1'b0;

   logic prod_ready, sum_valid, sum_ovf;
   logic signed [AW-1:0] sum;
   logic [CW-1:0] sum_cnt;
   logic prod_ready_s, sum_valid_s, sum_ovf_s;
   logic signed [AWS-1:0] sum_s;
   logic [CW-1:0] sum_cnt_s;

   logic [W-1:0]  exp_q[$];
   logic [WS-1:0] exp_s_q[$];
   logic [W-1:0]  exp_w;
   logic [WS-1:0] exp_s;
   int checks = 0;
   int passes = 0;

   mult_accum_seq dut (
      .clk_i(clk), .rst_i(rst), .prod_i(prod), .prod_valid_i(prod_valid),
      .prod_last_i(prod_last), .prod_ready_o(prod_ready), .sum_o(sum),
      .sum_cnt_o(sum_cnt), .sum_ovf_o(sum_ovf), .sum_valid_o(sum_valid),
      .sum_ready_i(sum_ready)
   );

   mult_accum_seq #(.R_WIDTH(RW), .ACC_WIDTH(AWS), .CNT_WIDTH(CW)) dut_s (
      .clk_i(clk), .rst_i(rst), .prod_i(prod), .prod_valid_i(prod_valid),
      .prod_last_i(prod_last), .prod_ready_o(prod_ready_s), .sum_o(sum_s),
      .sum_cnt_o(sum_cnt_s), .sum_ovf_o(sum_ovf_s), .sum_valid_o(sum_valid_s),
      .sum_ready_i(sum_ready)
   );

   always #5 clk = ~clk;

   // Presents one beat from a negedge and returns just after the edge that takes it.
   task automatic drive_beat(input logic signed [RW-1:0] v, input logic last, output int stalls);
      stalls = 0;
      @(negedge clk);
      prod = v; prod_last = last; prod_valid = 1'b1;
      while (!prod_ready && stalls < 20) begin
         @(negedge clk);
         stalls++;
      end
      @(posedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({sum_valid, sum_ovf, sum_cnt, sum} !== '0)
         $display("FAIL reset_outputs: got %h want 0", {sum_valid, sum_ovf, sum_cnt, sum});
      else passes++;
      rst = 1'b0;
      #1;
      checks++;
      if (prod_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", prod_ready);
      else passes++;
   endtask

   task automatic test_basic();
      int st, tot;
      logic signed [RW-1:0] vals [3];
      vals = '{43'sd3, -43'sd5, 43'sd10};
      tot = 0;
      sum_ready = 1'b1;
      exp_q.push_back({1'b0, 8'd3, 48'sd8});
      for (int i = 0; i < 3; i++) begin
         drive_beat(vals[i], i == 2, st);
         tot += st;
      end
      checks++;
      if (tot !== 0) $display("FAIL basic_ready: got %0d stall cycles want 0", tot);
      else passes++;
      @(negedge clk);
      checks++;
      if (sum_valid !== 1'b1) $display("FAIL basic_latency: got valid %b want 1", sum_valid);
      else passes++;
      exp_w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
      checks++;
      if ({sum_ovf, sum_cnt, sum} !== exp_w)
         $display("FAIL basic_result: got %h want %h", {sum_ovf, sum_cnt, sum}, exp_w);
      else passes++;
      prod_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({sum_valid, prod_ready} !== 2'b01)
         $display("FAIL basic_idle: got valid/ready %b want 01", {sum_valid, prod_ready});
      else passes++;
   endtask

   task automatic test_stall();
      int st;
      sum_ready = 1'b0;
      exp_q.push_back({1'b0, 8'd1, -48'sd7});
      drive_beat(-43'sd7, 1'b1, st);
      exp_w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({sum_valid, prod_ready, sum_ovf, sum_cnt, sum} !== {2'b10, exp_w})
            $display("FAIL stall_hold[%0d]: got %h want %h", i,
                     {sum_valid, prod_ready, sum_ovf, sum_cnt, sum}, {2'b10, exp_w});
         else passes++;
         if (i == 0) begin
            prod = 43'sd123; prod_last = 1'b1; prod_valid = 1'b1;
         end
      end
      sum_ready = 1'b1;
      prod_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({sum_valid, prod_ready} !== 2'b01)
         $display("FAIL stall_release: got valid/ready %b want 01", {sum_valid, prod_ready});
      else passes++;
      checks++;
      if ({sum_ovf, sum_cnt, sum} !== exp_w)
         $display("FAIL stall_keep: got %h want %h", {sum_ovf, sum_cnt, sum}, exp_w);
      else passes++;
   endtask

   task automatic test_overflow();
      int st;
      sum_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back({1'b0, CW'(OVF_LEN[k]), AW'(OVF_E48[k])});
         exp_s_q.push_back({1'b1, CW'(OVF_LEN[k]), AWS'(OVF_E44[k])});
         for (int j = 0; j < OVF_LEN[k]; j++)
            drive_beat(RW'(OVF_V[k][j]), j == OVF_LEN[k] - 1, st);
         @(negedge clk);
         exp_w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
         exp_s = exp_s_q.size() != 0 ? exp_s_q.pop_front() : 'x;
         checks++;
         if ({sum_valid_s, sum_ovf_s, sum_cnt_s, sum_s} !== {1'b1, exp_s})
            $display("FAIL ovf_sat[%0d]: got %h want %h", k,
                     {sum_valid_s, sum_ovf_s, sum_cnt_s, sum_s}, {1'b1, exp_s});
         else passes++;
         checks++;
         if ({sum_valid, sum_ovf, sum_cnt, sum} !== {1'b1, exp_w})
            $display("FAIL ovf_wide[%0d]: got %h want %h", k,
                     {sum_valid, sum_ovf, sum_cnt, sum}, {1'b1, exp_w});
         else passes++;
         prod_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_bubbles();
      logic signed [RW-1:0] vals [3];
      vals = '{43'sd1, 43'sd2, 43'sd4};
      sum_ready = 1'b1;
      exp_q.push_back({1'b0, 8'd3, 48'sd7});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         prod = vals[i]; prod_last = (i == 2); prod_valid = 1'b1;
         if (i < 2) begin
            @(negedge clk);
            prod = 43'sd99; prod_last = 1'b1; prod_valid = 1'b0;
         end
      end
      @(negedge clk);
      exp_w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
      checks++;
      if ({sum_valid, sum_ovf, sum_cnt, sum} !== {1'b1, exp_w})
         $display("FAIL bubbles_result: got %h want %h", {sum_valid, sum_ovf, sum_cnt, sum}, {1'b1, exp_w});
      else passes++;
      prod_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int st;
      sum_ready = 1'b1;
      drive_beat(43'sd100, 1'b0, st);
      drive_beat(43'sd200, 1'b0, st);
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({sum_valid, sum_ovf, sum_cnt, sum} !== '0)
         $display("FAIL reset_mid_outputs: got %h want 0", {sum_valid, sum_ovf, sum_cnt, sum});
      else passes++;
      prod_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back({1'b0, 8'd1, 48'sd5});
      drive_beat(43'sd5, 1'b1, st);
      @(negedge clk);
      exp_w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
      checks++;
      if ({sum_valid, sum_ovf, sum_cnt, sum} !== {1'b1, exp_w})
         $display("FAIL reset_mid_next: got %h want %h", {sum_valid, sum_ovf, sum_cnt, sum}, {1'b1, exp_w});
      else passes++;
      prod_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      sum_ready = 1'b1;
      for (int v = 1; v <= 3; v++) begin
         @(negedge clk);
         checks++;
         if (prod_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", v, prod_ready);
         else passes++;
         prod = RW'(v); prod_last = 1'b1; prod_valid = 1'b1;
         exp_q.push_back({1'b0, 8'd1, AW'(v)});
         @(negedge clk);
         exp_w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
         checks++;
         if ({prod_ready, sum_valid, sum_ovf, sum_cnt, sum} !== {2'b01, exp_w})
            $display("FAIL b2b_result[%0d]: got %h want %h", v,
                     {prod_ready, sum_valid, sum_ovf, sum_cnt, sum}, {2'b01, exp_w});
         else passes++;
      end
      @(negedge clk);
      prod_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random();
      int st, len;
      longint s, vals [6];
      for (int k = 0; k < 4; k++) begin
         sum_ready = 1'b0;
         len = $urandom_range(1, 6);
         s = 0;
         for (int j = 0; j < len; j++) begin
            vals[j] = longint'($urandom_range(0, 2000)) - 1000;
            s += vals[j];
         end
         exp_q.push_back({1'b0, CW'(len), AW'(s)});
         for (int j = 0; j < len; j++) drive_beat(RW'(vals[j]), j == len - 1, st);
         @(negedge clk);
         exp_w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
         checks++;
         if ({sum_valid, sum_ovf, sum_cnt, sum} !== {1'b1, exp_w})
            $display("FAIL random_result[%0d]: got %h want %h", k,
                     {sum_valid, sum_ovf, sum_cnt, sum}, {1'b1, exp_w});
         else passes++;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         sum_ready = 1'b1;
         prod_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (sum_valid !== 1'b0) $display("FAIL random_drain[%0d]: got valid %b want 0", k, sum_valid);
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_overflow();
      test_bubbles();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
